// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared Wishbone definitions for the scratchpad slice.
//   WB_DW / WB_SELW : bus data width and byte-enable width
//   wb_rsp_t        : one slot of the response pipeline {valid, err, data}
//   wb_byte_merge   : applies a byte-enable mask to a stored word
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_DW   = 32;
  localparam int WB_SELW = WB_DW / 8;

  typedef struct packed {
    logic             valid;
    logic             err;
    logic [WB_DW-1:0] data;
  } wb_rsp_t;

  // Lanes with sel=1 take the new byte, lanes with sel=0 keep the old byte.
  function automatic logic [WB_DW-1:0] wb_byte_merge(
    input logic [WB_DW-1:0]   old_word,
    input logic [WB_DW-1:0]   new_word,
    input logic [WB_SELW-1:0] sel
  );
    logic [WB_DW-1:0] merged;
    merged = old_word;
    for (int b = 0; b < WB_SELW; b++) begin
      if (sel[b]) begin
        merged[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        merged[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_rsp_pipe.sv
// -----------------------------------------------------------------------------
// wb_rsp_pipe
// DEPTH-deep shift register of wb_rsp_t. A response entering at i_* appears
// on o_* exactly DEPTH cycles later. i_flush clears every valid bit on the
// next edge (bus cycle abort); data/err bits are don't-care once invalid.
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_flush                 : synchronous clear of all valids
//   i_valid, i_err, i_data  : response launched this cycle
//   o_valid, o_err, o_data  : response leaving the last stage
// -----------------------------------------------------------------------------
module wb_rsp_pipe
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic             i_err,
  input  logic [WB_DW-1:0] i_data,
  output logic             o_valid,
  output logic             o_err,
  output logic [WB_DW-1:0] o_data
);

  wb_rsp_t r_stage [DEPTH];
  wb_rsp_t w_next  [DEPTH];

  // Next contents: shift by one stage, then kill every valid on a flush.
  always_comb begin
    w_next[0] = '{valid: i_valid, err: i_err, data: i_data};
    for (int k = 1; k < DEPTH; k++) begin
      w_next[k] = r_stage[k-1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      w_next[k].valid = w_next[k].valid & ~i_flush;
    end
  end

  // Stage registers; reset drops every in-flight response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      r_stage <= w_next;
    end
  end

  assign o_valid = r_stage[DEPTH-1].valid;
  assign o_err   = r_stage[DEPTH-1].err;
  assign o_data  = r_stage[DEPTH-1].data;

endmodule

// File: rtl/wb_scratchpad.sv
// -----------------------------------------------------------------------------
// wb_scratchpad
// Pipelined Wishbone slave RAM of 2**AW 32-bit words at byte address BASE.
// Byte-masked writes and word reads complete with ack (or err for addresses
// outside the window) exactly ACK_LAT cycles after acceptance. At most
// MAX_OUT requests are in flight; stall is raised while that limit is reached.
//   i_clk, i_rst_n              : clock, async active-low reset
//   i_s_cyc, i_s_stb_ena        : bus cycle, request strobe
//   i_s_stb_we/addr/data/sel    : request attributes
//   o_s_stb_rdy (= !o_s_stall)  : request may be accepted
//   o_s_ack, o_s_err            : one-cycle completion pulses
//   o_s_stall                   : back-pressure
//   o_s_*_rdy                   : always 1
//   o_rdata                     : read data, valid with o_s_ack of a read
// -----------------------------------------------------------------------------
module wb_scratchpad
  import wb_pkg::*;
#(
  parameter int          AW      = 6,
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter int          ACK_LAT = 2,
  parameter int          MAX_OUT = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_s_cyc,
  input  logic               i_s_stb_ena,
  input  logic               i_s_stb_we,
  input  logic [31:0]        i_s_stb_addr,
  input  logic [WB_DW-1:0]   i_s_stb_data,
  input  logic [WB_SELW-1:0] i_s_stb_sel,
  output logic               o_s_stb_rdy,
  output logic               o_s_ack,
  output logic               o_s_stall,
  output logic               o_s_err,
  output logic               o_s_ack_rdy,
  output logic               o_s_stall_rdy,
  output logic               o_s_err_rdy,
  output logic [WB_DW-1:0]   o_rdata
);

  localparam int             DEPTH     = 2 ** AW;
  localparam int             OW        = $clog2(MAX_OUT + 1);
  localparam logic [OW-1:0]  MAX_OUT_C = OW'(MAX_OUT);
  localparam logic [OW-1:0]  ONE_C     = OW'(1);

  logic [WB_DW-1:0] r_mem [DEPTH];
  logic [OW-1:0]    r_out;
  logic [OW-1:0]    w_out_next;

  logic             w_stall;
  logic             w_accept;
  logic             w_hit;
  logic [AW-1:0]    w_idx;
  logic             w_rsp_valid;
  logic             w_rsp_err;
  logic [WB_DW-1:0] w_rsp_data;
  logic             w_pipe_valid;
  logic             w_pipe_err;
  logic [WB_DW-1:0] w_pipe_data;
  logic             w_unused;

  // No look-ahead: a response retiring this cycle does not release the stall.
  assign w_stall  = i_s_cyc & (r_out == MAX_OUT_C);
  assign w_accept = i_s_cyc & i_s_stb_ena & ~w_stall;
  assign w_hit    = (i_s_stb_addr[31:AW+2] == BASE[31:AW+2]);
  assign w_idx    = i_s_stb_addr[AW+1:2];
  assign w_unused = ^i_s_stb_addr[1:0];

  // Response launched on accept; RAM is read before this edge's write lands.
  always_comb begin
    w_rsp_valid = w_accept;
    w_rsp_err   = w_accept & ~w_hit;
    w_rsp_data  = '0;
    if (w_accept & w_hit & ~i_s_stb_we) begin
      w_rsp_data = r_mem[w_idx];
    end else begin
      w_rsp_data = '0;
    end
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_rst_n & w_accept & w_hit & i_s_stb_we) begin
      r_mem[w_idx] <= wb_byte_merge(r_mem[w_idx], i_s_stb_data, i_s_stb_sel);
    end
  end

  // Outstanding count: abort clears it, simultaneous accept+retire is a no-op.
  always_comb begin
    w_out_next = r_out;
    if (!i_s_cyc) begin
      w_out_next = '0;
    end else if (w_accept & ~w_pipe_valid) begin
      w_out_next = r_out + ONE_C;
    end else if (~w_accept & w_pipe_valid) begin
      w_out_next = r_out - ONE_C;
    end else begin
      w_out_next = r_out;
    end
  end

  // Outstanding counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= w_out_next;
    end
  end

  wb_rsp_pipe #(
    .DEPTH (ACK_LAT)
  ) u_rsp_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (~i_s_cyc),
    .i_valid (w_rsp_valid),
    .i_err   (w_rsp_err),
    .i_data  (w_rsp_data),
    .o_valid (w_pipe_valid),
    .o_err   (w_pipe_err),
    .o_data  (w_pipe_data)
  );

  assign o_s_stall     = w_stall;
  assign o_s_stb_rdy   = ~w_stall;
  assign o_s_ack       = w_pipe_valid & ~w_pipe_err;
  assign o_s_err       = w_pipe_valid & w_pipe_err;
  assign o_rdata       = w_pipe_data;
  assign o_s_ack_rdy   = 1'b1;
  assign o_s_stall_rdy = 1'b1;
  assign o_s_err_rdy   = 1'b1;

endmodule

// File: tb/tb_wb_scratchpad.sv
// -----------------------------------------------------------------------------
// tb_wb_scratchpad
// Directed vector table for the basic write/read/stall sequences, hand-written
// sequences for error, abort and async reset, then randomized traffic checked
// against a transaction-level model (word array + queue of due completions).
// -----------------------------------------------------------------------------
module tb_wb_scratchpad;

  localparam int          AW      = 6;
  localparam logic [31:0] BASE    = 32'h0000_0000;
  localparam int          ACK_LAT = 2;
  localparam int          MAX_OUT = 2;
  localparam int          NWORDS  = 2 ** AW;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic        stb_rdy, ack, stall, err, ack_rdy, stall_rdy, err_rdy;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  wb_scratchpad #(
    .AW (AW), .BASE (BASE), .ACK_LAT (ACK_LAT), .MAX_OUT (MAX_OUT)
  ) dut (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_s_cyc (cyc), .i_s_stb_ena (stb), .i_s_stb_we (we),
    .i_s_stb_addr (addr), .i_s_stb_data (wdata), .i_s_stb_sel (sel),
    .o_s_stb_rdy (stb_rdy), .o_s_ack (ack), .o_s_stall (stall), .o_s_err (err),
    .o_s_ack_rdy (ack_rdy), .o_s_stall_rdy (stall_rdy), .o_s_err_rdy (err_rdy),
    .o_rdata (rdata)
  );

  typedef struct {
    logic        cyc, stb, we;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic        e_ack, e_err, e_stall, chk_rd;
    logic [31:0] e_rdata;
  } vec_t;

  typedef struct {
    int          due;
    bit          err;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          t = 0;
  bit          last_acc;
  exp_t        q[$];
  logic [31:0] mem_m [NWORDS];
  vec_t        tbl [22];
  vec_t        nv;

  function automatic vec_t mk(logic c, logic s, logic w, logic [31:0] a, logic [31:0] d,
                              logic [3:0] sl, logic ea, logic ee, logic es,
                              logic cr, logic [31:0] er);
    vec_t v;
    v.cyc = c; v.stb = s; v.we = w; v.addr = a; v.wdata = d; v.sel = sl;
    v.e_ack = ea; v.e_err = ee; v.e_stall = es; v.chk_rd = cr; v.e_rdata = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, t);
    end
  endtask

  // One bus cycle; entered just after a rising edge, leaves just after the next.
  task automatic run_cycle(input logic c, input logic s, input logic w,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl,
                           input bit use_tbl, input vec_t v);
    bit   m_stall, have, hit;
    exp_t head, e;
    int   idx;
    cyc = c; stb = s; we = w; addr = a; wdata = d; sel = sl;
    @(negedge clk);
    m_stall = c && (q.size() == MAX_OUT);
    have = 0;
    head = '{due: 0, err: 0, rd: 0, data: 32'h0};
    if (q.size() > 0 && q[0].due == t) begin
      have = 1;
      head = q.pop_front();
    end
    if (use_tbl) begin
      chk("tbl_ack", {31'h0, ack}, {31'h0, v.e_ack});
      chk("tbl_err", {31'h0, err}, {31'h0, v.e_err});
      chk("tbl_stall", {31'h0, stall}, {31'h0, v.e_stall});
      chk("tbl_rdy", {31'h0, stb_rdy}, {31'h0, ~v.e_stall});
      if (v.chk_rd) chk("tbl_rdata", rdata, v.e_rdata);
    end else begin
      chk("ack", {31'h0, ack}, {31'h0, have && !head.err});
      chk("err", {31'h0, err}, {31'h0, have && head.err});
      chk("stall", {31'h0, stall}, {31'h0, m_stall});
      chk("rdy", {31'h0, stb_rdy}, {31'h0, !m_stall});
      if (have && (head.err || head.rd)) chk("rdata", rdata, head.data);
    end
    last_acc = c && s && !m_stall;
    if (last_acc) begin
      hit   = ((a >> (AW + 2)) == (BASE >> (AW + 2)));
      idx   = int'((a >> 2) % NWORDS);
      e.due = t + ACK_LAT;
      e.err = !hit;
      e.rd  = !w;
      e.data = (hit && !w) ? mem_m[idx] : 32'h0;
      q.push_back(e);
      if (hit && w) begin
        for (int b = 0; b < 4; b++) if (sl[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
      end
    end
    if (!c) q.delete();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic mc(input logic c, input logic s, input logic w,
                    input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
    run_cycle(c, s, w, a, d, sl, 1'b0, nv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) mc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nv = mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    // Write/read, byte-masked overwrite, back-to-back reads hitting the stall limit.
    tbl[0]  = mk(1'b1,1'b1,1'b1,32'h8,32'hDEADBEEF,4'hF, 1'b0,1'b0,1'b0, 1'b0,32'h0);
    tbl[1]  = mk(1'b1,1'b0,1'b0,32'h0,32'h0,4'h0,        1'b0,1'b0,1'b0, 1'b0,32'h0);
    tbl[2]  = mk(1'b1,1'b1,1'b0,32'h8,32'h0,4'h0,        1'b1,1'b0,1'b0, 1'b0,32'h0);
    tbl[3]  = mk(1'b1,1'b0,1'b0,32'h0,32'h0,4'h0,        1'b0,1'b0,1'b0, 1'b0,32'h0);
    tbl[4]  = mk(1'b1,1'b0,1'b0,32'h0,32'h0,4'h0,        1'b1,1'b0,1'b0, 1'b1,32'hDEADBEEF);
    tbl[5]  = mk(1'b1,1'b0,1'b0,32'h0,32'h0,4'h0,        1'b0,1'b0,1'b0, 1'b0,32'h0);
    tbl[6]  = mk(1'b1,1'b1,1'b1,32'h8,32'h11223344,4'h5, 1'b0,1'b0,1'b0, 1'b0,32'h0);
    tbl[7]  = mk(1'b1,1'b0,1'b0,32'h0,32'h0,4'h0,        1'b0,1'b0,1'b0, 1'b0,32'h0);
    tbl[8]  = mk(1'b1,1'b1,1'b0,32'h8,32'h0,4'h0,        1'b1,1'b0,1'b0, 1'b0,32'h0);
    tbl[9]  = mk(1'b1,1'b0,1'b0,32'h0,32'h0,4'h0,        1'b0,1'b0,1'b0, 1'b0,32'h0);
    tbl[10] = mk(1'b1,1'b0,1'b0,32'h0,32'h0,4'h0,        1'b1,1'b0,1'b0, 1'b1,32'hDE22BE44);
    tbl[11] = mk(1'b1,1'b1,1'b1,32'h0,32'hA0A0A0A0,4'hF, 1'b0,1'b0,1'b0, 1'b0,32'h0);
    tbl[12] = mk(1'b1,1'b1,1'b1,32'h4,32'hB1B1B1B1,4'hF, 1'b0,1'b0,1'b0, 1'b0,32'h0);
    tbl[13] = mk(1'b1,1'b0,1'b0,32'h0,32'h0,4'h0,        1'b1,1'b0,1'b1, 1'b0,32'h0);
    tbl[14] = mk(1'b1,1'b0,1'b0,32'h0,32'h0,4'h0,        1'b1,1'b0,1'b0, 1'b0,32'h0);
    tbl[15] = mk(1'b1,1'b1,1'b0,32'h0,32'h0,4'h0,        1'b0,1'b0,1'b0, 1'b0,32'h0);
    tbl[16] = mk(1'b1,1'b1,1'b0,32'h4,32'h0,4'h0,        1'b0,1'b0,1'b0, 1'b0,32'h0);
    tbl[17] = mk(1'b1,1'b1,1'b0,32'h8,32'h0,4'h0,        1'b1,1'b0,1'b1, 1'b1,32'hA0A0A0A0);
    tbl[18] = mk(1'b1,1'b1,1'b0,32'h8,32'h0,4'h0,        1'b1,1'b0,1'b0, 1'b1,32'hB1B1B1B1);
    tbl[19] = mk(1'b1,1'b0,1'b0,32'h0,32'h0,4'h0,        1'b0,1'b0,1'b0, 1'b0,32'h0);
    tbl[20] = mk(1'b1,1'b0,1'b0,32'h0,32'h0,4'h0,        1'b1,1'b0,1'b0, 1'b1,32'hDE22BE44);
    tbl[21] = mk(1'b0,1'b0,1'b0,32'h0,32'h0,4'h0,        1'b0,1'b0,1'b0, 1'b0,32'h0);

    // Reset state, with cyc already high.
    rst_n = 1'b0; cyc = 1'b1; stb = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; sel = 4'h0;
    #3;
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_rdy", {31'h0, stb_rdy}, 32'h1);
    chk("rst_rdata", rdata, 32'h0);
    chk("tied_rdy", {29'h0, ack_rdy, stall_rdy, err_rdy}, 32'h7);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Give every word a known value so random reads are predictable.
    for (int i = 0; i < NWORDS; i++) begin
      for (int tries = 0; tries < 8; tries++) begin
        mc(1'b1, 1'b1, 1'b1, 32'(i * 4), $urandom, 4'hF);
        if (last_acc) break;
      end
      if (!last_acc) chk("prefill_accept", 32'h0, 32'h1);
    end
    idle(ACK_LAT + 1);

    for (int i = 0; i < 22; i++) begin
      run_cycle(tbl[i].cyc, tbl[i].stb, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].sel,
                1'b1, tbl[i]);
    end

    // Out-of-window read and write: err only, RAM untouched, then a normal read.
    mc(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    idle(2);
    mc(1'b1, 1'b1, 1'b1, 32'h108, 32'h0, 4'hF);
    idle(2);
    mc(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    idle(3);

    // Abort: two reads accepted, then cyc drops; nothing further completes.
    mc(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    mc(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    mc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mc(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    if (!last_acc) chk("abort_reaccept", 32'h0, 32'h1);
    idle(3);

    // Async reset in the middle of a pipeline holding a due response.
    mc(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    mc(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    cyc = 1'b1; stb = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ack", {31'h0, ack}, 32'h0);
    chk("arst_err", {31'h0, err}, 32'h0);
    chk("arst_stall", {31'h0, stall}, 32'h0);
    chk("arst_rdata", rdata, 32'h0);
    q.delete();
    @(posedge clk); #1; t++;
    @(posedge clk); #1; t++;
    rst_n = 1'b1;
    mc(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    idle(3);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 9) == 0) ? $urandom : {24'h0, 6'($urandom), 2'($urandom)};
      mc(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom), ra, $urandom, 4'($urandom));
    end
    idle(ACK_LAT + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
